// File: rtl/vga_pkg.sv
// Shared raster and framebuffer constants plus the CPU-port FSM state type
// for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int FB_SIZE = FB_W * FB_H;

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_ACK  = 1'b1
    } cpu_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address row*160+col, built from shifts so no multiplier
// is needed on the video fetch path.
module fb_addr_calc (
    input  logic [6:0]  i_row,
    input  logic [7:0]  i_col,
    output logic [14:0] o_addr
);

    assign o_addr = 15'({i_row, 7'b0}) + 15'({i_row, 5'b0}) + 15'(i_col);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port video RAM between 4:1 scan-out (one slot in four)
// and a req/ack CPU port, and produces the colour for the current raster pixel.
module vga_fb_arbiter #(
    parameter int FB_W    = vga_pkg::FB_W,
    parameter int FB_H    = vga_pkg::FB_H,
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  pixel_counter,
    input  logic [9:0]  line_counter,
    output logic [7:0]  pixel_color,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata
);

    import vga_pkg::*;

    logic [1:0]  w_slot;
    logic        w_last_col;
    logic [9:0]  w_next_line;
    logic [9:0]  w_tgt_line;
    logic [7:0]  w_tgt_grp;
    logic        w_tgt_ok;
    logic        w_vid_due;
    logic        w_in_range;
    logic        w_grant;
    logic [14:0] w_vid_addr;

    cpu_state_t  r_state;
    logic        r_cpu_ack;
    logic        r_rd_ok;
    logic        r_vid_pend;
    logic        r_fetched;
    logic [7:0]  r_prefetch;
    logic [7:0]  r_pixel_color;

    assign w_slot      = pixel_counter[1:0];
    assign w_last_col  = (pixel_counter == 10'(H_TOTAL - 4));
    assign w_next_line = (line_counter == 10'(V_TOTAL - 1)) ? 10'd0 : line_counter + 10'd1;

    // Each fetch targets the next 4-pixel group; the one at the end of the
    // line primes group 0 of the following line.
    assign w_tgt_line = w_last_col ? w_next_line : line_counter;
    assign w_tgt_grp  = w_last_col ? 8'd0 : pixel_counter[9:2] + 8'd1;
    assign w_tgt_ok   = (w_tgt_grp < 8'(FB_W)) && (w_tgt_line < 10'(FB_H * 4));
    assign w_vid_due  = enable && (w_slot == 2'd0) && w_tgt_ok;

    assign w_in_range = (cpu_addr < 15'(FB_W * FB_H));
    assign w_grant    = (r_state == CPU_IDLE) && cpu_req && !w_vid_due;

    fb_addr_calc u_addr (
        .i_row  (w_tgt_line[8:2]),
        .i_col  (w_tgt_grp),
        .o_addr (w_vid_addr)
    );

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_vid_due) begin
            mem_addr = w_vid_addr;
        end else if (w_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we && w_in_range;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CPU_IDLE;
            r_cpu_ack <= 1'b0;
            r_rd_ok   <= 1'b0;
        end else begin
            case (r_state)
                CPU_IDLE: begin
                    if (w_grant) begin
                        r_state   <= CPU_ACK;
                        r_cpu_ack <= 1'b1;
                        r_rd_ok   <= !cpu_we && w_in_range;
                    end
                end
                CPU_ACK: begin
                    r_state   <= CPU_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_rd_ok   <= 1'b0;
                end
                default: begin
                    r_state   <= CPU_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_rd_ok   <= 1'b0;
                end
            endcase
        end
    end

    // The RAM's own output register holds the granted word for the whole ACK
    // cycle, so the read data is presented straight from it.
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = (r_cpu_ack && r_rd_ok) ? mem_rdata : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vid_pend    <= 1'b0;
            r_fetched     <= 1'b0;
            r_prefetch    <= '0;
            r_pixel_color <= '0;
        end else begin
            r_vid_pend <= w_vid_due;
            if (r_vid_pend) begin
                r_prefetch <= mem_rdata;
            end
            if (w_slot == 2'd0) begin
                r_fetched <= w_vid_due;
            end
            if (w_slot == 2'd3) begin
                r_pixel_color <= r_fetched ? r_prefetch : 8'd0;
            end
        end
    end

    assign pixel_color = r_pixel_color;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a shadow framebuffer predicts every
// scanned pixel and queued CPU read data is compared when cpu_ack arrives.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  pixel_counter;
    logic [9:0]  line_counter;
    logic [7:0]  pixel_color;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    logic [7:0]  ram    [0:32767];
    logic [7:0]  shadow [0:19199];
    logic [7:0]  pix_q  [$];
    logic [7:0]  rd_q   [$];
    logic        bad_we = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    vga_fb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pixel_counter (pixel_counter),
        .line_counter  (line_counter),
        .pixel_color   (pixel_color),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rdata     (cpu_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, preloaded with the low address byte.
    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'(i);
        for (int i = 0; i < 19200; i++) shadow[i] = 8'(i);
        mem_rdata = 8'd0;
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we && mem_addr >= 15'd19200) bad_we = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Drives the tail of the previous line (to prime group 0) then checks a
    // full line; pixels in [blank_lo, blank_hi] are expected dark.
    task automatic sweep(input int line, input int blank_lo, input int blank_hi);
        int prev;
        logic [7:0] exp;
        prev = (line == 0) ? 524 : line - 1;
        for (int p = 796; p < 800; p++) begin
            @(posedge clk); #1;
            line_counter  = 10'(prev);
            pixel_counter = 10'(p);
        end
        for (int p = 0; p < 800; p++) begin
            @(posedge clk); #1;
            line_counter  = 10'(line);
            pixel_counter = 10'(p);
            if (enable && line < 480 && p < 640 && !(p >= blank_lo && p <= blank_hi))
                exp = shadow[(line / 4) * 160 + p / 4];
            else
                exp = 8'd0;
            pix_q.push_back(exp);
            @(negedge clk);
            check($sformatf("pix L%0d p%0d", line, p), 32'(pixel_color), 32'(pix_q.pop_front()));
            if (!enable && !cpu_req && (p % 4 == 0)) begin
                check("idle_addr", 32'(mem_addr), 32'd0);
                check("idle_we", 32'(mem_we), 32'd0);
            end
        end
    endtask

    task automatic wait_pix(input int line, input int p);
        int n;
        n = 0;
        while (!(line_counter == 10'(line) && pixel_counter == 10'(p)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("wait_tmo", 32'd0, 32'd1);
    endtask

    // Caller is at posedge+1; leaves the bench at posedge+1 after the ack cycle.
    task automatic cpu_txn(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                           input int exp_lat, input logic [7:0] exp_rd);
        int  n;
        logic got;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        if (!we) rd_q.push_back(exp_rd);
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (cpu_ack) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        if (got) check("ack_lat", 32'(n), 32'(exp_lat));
        if (!we) begin
            if (got) check("cpu_rdata", 32'(cpu_rdata), 32'(rd_q.pop_front()));
            else void'(rd_q.pop_front());
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        pixel_counter = 10'd0;
        line_counter  = 10'd0;
        cpu_req       = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = 15'd0;
        cpu_wdata     = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix", 32'(pixel_color), 32'd0);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;

        sweep(0, -1, -1);
        sweep(8, -1, -1);

        fork
            sweep(3, -1, -1);
            begin
                wait_pix(3, 200);
                @(posedge clk); #1;
                shadow[161] = 8'hE3;
                cpu_txn(1'b1, 15'd161, 8'hE3, 2, 8'h00);
            end
        join
        sweep(4, -1, -1);

        fork
            sweep(5, -1, -1);
            begin
                wait_pix(5, 99);
                @(posedge clk); #1;
                cpu_txn(1'b0, 15'd161, 8'h00, 3, 8'hE3);
            end
        join

        fork
            sweep(6, -1, -1);
            begin
                wait_pix(6, 200);
                @(posedge clk); #1;
                cpu_txn(1'b1, 15'd19200, 8'h55, 2, 8'h00);
                cpu_txn(1'b0, 15'd19205, 8'h00, 2, 8'h00);
            end
        join
        check("oor_ram", 32'(ram[19200]), 32'h00);

        sweep(480, -1, -1);

        enable = 1'b0;
        fork
            sweep(10, -1, -1);
            begin
                wait_pix(10, 99);
                @(posedge clk); #1;
                shadow[1000] = 8'h12;
                shadow[1001] = 8'h34;
                cpu_txn(1'b1, 15'd1000, 8'h12, 2, 8'h00);
                cpu_txn(1'b0, 15'd1000, 8'h00, 2, 8'h12);
                cpu_txn(1'b1, 15'd1001, 8'h34, 2, 8'h00);
                cpu_txn(1'b0, 15'd1001, 8'h00, 2, 8'h34);
            end
        join
        enable = 1'b1;

        fork
            sweep(12, 102, 107);
            begin
                wait_pix(12, 100);
                @(posedge clk); #1;
                cpu_we   = 1'b0;
                cpu_addr = 15'd5;
                cpu_req  = 1'b1;
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("rst_mid_ack", 32'(cpu_ack), 32'd0);
                check("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
                check("rst_mid_pix", 32'(pixel_color), 32'd0);
                reset   = 1'b0;
                cpu_req = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("rst_no_ack", 32'(cpu_ack), 32'd0);
                end
            end
        join

        check("oor_we", 32'(bad_we), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
